display_timings: RTL and testbench
==================================

Name: display_timings

Overview:
- Raster timing generator for the display controller.
- Produces pixel coordinates, sync pulses and data-enable from the pixel clock.
- Sits directly upstream of the test card and other pattern generators: o_x/o_y feed their 16-bit coordinate inputs; o_hs/o_vs/o_de go to the output encoder (VGA/DVI) alongside the pattern colour.
- Default parameters give 640x480 @ 60 Hz (25.2 MHz pixel clock).

Parameters:
- H_RES, 640, active pixels per line
- V_RES, 480, active lines per frame
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low, 1 = active-high)
- V_POL, 0, vsync active level (0 = active-low, 1 = active-high)

Ports:
- i_pix_clk  input  1  pixel clock; all logic on rising edge
- i_rst  input  1  reset, synchronous, active-high
- o_hs  output  1  horizontal sync, level per H_POL
- o_vs  output  1  vertical sync, level per V_POL
- o_de  output  1  data enable; high in active region
- o_frame  output  1  one-cycle pulse at x=0, y=0
- o_line  output  1  one-cycle pulse at x=0 of every line, including blanking lines
- o_x  output  16  horizontal position, 0..H_TOTAL-1, unsigned
- o_y  output  16  vertical position, 0..V_TOTAL-1, unsigned

Behaviour:
- Derived constants:
  - H_TOTAL = H_RES+H_FP+H_SYNC+H_BP (default 800)
  - V_TOTAL = V_RES+V_FP+V_SYNC+V_BP (default 525)
  - Both must be <= 65536; widths are fixed at 16 bits.
- Counters:
  - o_x and o_y are registered counters.
  - o_x increments every cycle.
  - At o_x = H_TOTAL-1, o_x wraps to 0 and o_y increments.
  - At o_x = H_TOTAL-1 with o_y = V_TOTAL-1, both wrap to 0.
- Decoded outputs (o_hs, o_vs, o_de, o_frame, o_line):
  - Each is registered and computed from the next counter values, so it is aligned with o_x/o_y in the same cycle (zero relative latency).
  - Downstream stages can treat all outputs as one bundle.
- Active region: o_de = 1 iff o_x < H_RES and o_y < V_RES.
- Horizontal sync: o_hs is at level H_POL iff H_RES+H_FP <= o_x < H_RES+H_FP+H_SYNC (default 656..751); otherwise at level ~H_POL.
- Vertical sync:
  - o_vs is at level V_POL iff V_RES+V_FP <= o_y < V_RES+V_FP+V_SYNC (default 490..491); otherwise at level ~V_POL.
  - o_vs changes only when o_x = 0.
- Reset (i_rst high at a clock edge):
  - o_x=0, o_y=0, o_de=0, o_frame=0, o_line=0.
  - o_hs=~H_POL, o_vs=~V_POL.
  - Outputs are held while i_rst remains high.
- First cycle after reset release: o_x=0, o_y=0, o_de=1, o_frame=1, o_line=1.
- Reset mid-frame: aborts immediately at the next edge; no partial sync pulse is extended; the frame restarts from (0,0).
- No handshake: the generator free-runs and cannot be stalled. Downstream stages must absorb one pixel per clock.

Optional Feature:
- Macro: DISPLAY_TIMINGS_FRAME_COUNT_EN.
- Defined:
  - Adds output port o_frame_count, 16-bit, registered.
  - Resets to 0.
  - Increments by 1 in the cycle o_frame is asserted, excluding the first o_frame after reset, so it reads 0 through frame 0.
  - Wraps 65535 -> 0.
  - Intended for animated pattern generators.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset held 5 cycles, then released -> during reset o_x=0, o_y=0, o_de=0, o_hs=1, o_vs=1 (default polarity); first released cycle o_de=1, o_frame=1, o_line=1.
- Run one line from reset -> o_de high for x=0..639; o_hs=0 for exactly x=656..751 (96 cycles); x wraps 799->0 with y 0->1; o_line pulses at x=0 only.
- Run one full frame -> o_vs=0 exactly while y=490..491 (1600 cycles), transitions at x=0; y wraps 524->0; o_frame pulses once per 420000 cycles; o_de high count = 307200.
- Assert i_rst for 1 cycle at x=700, y=491 (during sync) -> next cycle o_hs=1, o_vs=1, x=0, y=0; after release the frame proceeds from (0,0) with correct timing.
- Parameters H_RES=1280, V_RES=720, H_FP=110, H_SYNC=40, H_BP=220, V_FP=5, V_SYNC=5, V_BP=20, H_POL=1, V_POL=1 -> H_TOTAL=1650, V_TOTAL=750; o_hs=1 for x=1390..1429; o_vs=1 for y=725..729.
- With DISPLAY_TIMINGS_FRAME_COUNT_EN, run 3 frames -> o_frame_count reads 0, 1, 2 in frames 0, 1, 2; value changes on the o_frame cycle; reset returns it to 0.

Source files
------------

// File: rtl/display_timings.sv
// Raster timing generator: pixel/line counters with aligned sync, data-enable and frame/line strobes.
// Optional macro DISPLAY_TIMINGS_FRAME_COUNT_EN adds a 16-bit frame counter output.
module display_timings #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0
) (
  input  logic        i_pix_clk,
  input  logic        i_rst,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic        o_frame,
  output logic        o_line,
  output logic [15:0] o_x,
  output logic [15:0] o_y
`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
  ,
  output logic [15:0] o_frame_count
`endif
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [16:0] H_ACT    = 17'(H_RES);
  localparam logic [16:0] V_ACT    = 17'(V_RES);
  localparam logic [16:0] HS_START = 17'(H_RES + H_FP);
  localparam logic [16:0] HS_END   = 17'(H_RES + H_FP + H_SYNC);
  localparam logic [16:0] VS_START = 17'(V_RES + V_FP);
  localparam logic [16:0] VS_END   = 17'(V_RES + V_FP + V_SYNC);

  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic        run_q;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        de_q, de_d;
  logic        frame_q, frame_d;
  logic        line_q, line_d;

  // The first edge after reset release parks the counters at (0,0) so the
  // first released cycle presents the origin with its strobes.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (!run_q) begin
      x_d = 16'd0;
      y_d = 16'd0;
    end else if (x_q == H_LAST) begin
      x_d = 16'd0;
      if (y_q == V_LAST) begin
        y_d = 16'd0;
      end else begin
        y_d = y_q + 16'd1;
      end
    end else begin
      x_d = x_q + 16'd1;
    end
  end

  // Decode from the next counter values so registered outputs line up with o_x/o_y.
  always_comb begin
    de_d    = ({1'b0, x_d} < H_ACT) && ({1'b0, y_d} < V_ACT);
    hs_d    = (({1'b0, x_d} >= HS_START) && ({1'b0, x_d} < HS_END)) ? H_POL : ~H_POL;
    vs_d    = (({1'b0, y_d} >= VS_START) && ({1'b0, y_d} < VS_END)) ? V_POL : ~V_POL;
    line_d  = (x_d == 16'd0);
    frame_d = (x_d == 16'd0) && (y_d == 16'd0);
  end

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      x_q     <= 16'd0;
      y_q     <= 16'd0;
      run_q   <= 1'b0;
      hs_q    <= ~H_POL;
      vs_q    <= ~V_POL;
      de_q    <= 1'b0;
      frame_q <= 1'b0;
      line_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      run_q   <= 1'b1;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      frame_q <= frame_d;
      line_q  <= line_d;
    end
  end

`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
  logic [15:0] fcount_q, fcount_d;

  // The frame strobe that follows reset release is frame 0 and does not count.
  always_comb begin
    if (frame_d && run_q) begin
      fcount_d = fcount_q + 16'd1;
    end else begin
      fcount_d = fcount_q;
    end
  end

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      fcount_q <= 16'd0;
    end else begin
      fcount_q <= fcount_d;
    end
  end

  assign o_frame_count = fcount_q;
`endif

  assign o_x     = x_q;
  assign o_y     = y_q;
  assign o_hs    = hs_q;
  assign o_vs    = vs_q;
  assign o_de    = de_q;
  assign o_frame = frame_q;
  assign o_line  = line_q;

endmodule

// File: tb/tb_display_timings.sv
// Self-checking bench for display_timings: three parameter sets checked every cycle
// against an arithmetic raster model driven by a cycle index since reset release.
module tb_display_timings;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n = -1;   // cycles since reset release; -1 while held in reset

  // instance A: default 640x480, instance B: 720p-style, instance C: tiny raster for full frames
  logic        a_hs, a_vs, a_de, a_fr, a_ln;
  logic [15:0] a_x, a_y;
  logic        b_hs, b_vs, b_de, b_fr, b_ln;
  logic [15:0] b_x, b_y;
  logic        c_hs, c_vs, c_de, c_fr, c_ln;
  logic [15:0] c_x, c_y;
`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
  logic [15:0] a_fc, b_fc, c_fc;
  localparam bit FC_EN = 1'b1;
`else
  logic [15:0] a_fc = 16'd0, b_fc = 16'd0, c_fc = 16'd0;
  localparam bit FC_EN = 1'b0;
`endif

  display_timings u_a (
    .i_pix_clk(clk), .i_rst(rst), .o_hs(a_hs), .o_vs(a_vs), .o_de(a_de),
    .o_frame(a_fr), .o_line(a_ln), .o_x(a_x), .o_y(a_y)
`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
    , .o_frame_count(a_fc)
`endif
  );

  display_timings #(
    .H_RES(1280), .V_RES(720), .H_FP(110), .H_SYNC(40), .H_BP(220),
    .V_FP(5), .V_SYNC(5), .V_BP(20), .H_POL(1'b1), .V_POL(1'b1)
  ) u_b (
    .i_pix_clk(clk), .i_rst(rst), .o_hs(b_hs), .o_vs(b_vs), .o_de(b_de),
    .o_frame(b_fr), .o_line(b_ln), .o_x(b_x), .o_y(b_y)
`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
    , .o_frame_count(b_fc)
`endif
  );

  display_timings #(
    .H_RES(8), .V_RES(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_FP(2), .V_SYNC(2), .V_BP(3), .H_POL(1'b0), .V_POL(1'b1)
  ) u_c (
    .i_pix_clk(clk), .i_rst(rst), .o_hs(c_hs), .o_vs(c_vs), .o_de(c_de),
    .o_frame(c_fr), .o_line(c_ln), .o_x(c_x), .o_y(c_y)
`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
    , .o_frame_count(c_fc)
`endif
  );

  // aggregate counters over the first line / first frame after the initial release
  int a_hs_cnt = 0;
  int b_hs_cnt = 0;
  int c_de_cnt = 0;
  int c_fr_cnt = 0;
  int a_ln_cnt = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed=%0d expected=%0d", tag, n, obs, exp);
    end
  endtask

  // Reference raster: position is the cycle index folded into line and frame lengths.
  task automatic mcheck(input string tag,
                        input int hr, input int hfp, input int hsw, input int hbp,
                        input int vr, input int vfp, input int vsw, input int vbp,
                        input bit hpol, input bit vpol,
                        input logic hs_o, input logic vs_o, input logic de_o,
                        input logic fr_o, input logic ln_o,
                        input logic [15:0] x_o, input logic [15:0] y_o, input logic [15:0] fc_o);
    int ht, vt, ex, ey, efc;
    logic ehs, evs, ede, efr, eln;
    ht = hr + hfp + hsw + hbp;
    vt = vr + vfp + vsw + vbp;
    if (n < 0) begin
      ex = 0; ey = 0; efc = 0;
      ede = 1'b0; efr = 1'b0; eln = 1'b0;
      ehs = ~hpol; evs = ~vpol;
    end else begin
      ex  = n % ht;
      ey  = (n / ht) % vt;
      efc = (n / (ht * vt)) % 65536;
      ede = (ex < hr) && (ey < vr);
      ehs = (ex >= hr + hfp && ex < hr + hfp + hsw) ? hpol : ~hpol;
      evs = (ey >= vr + vfp && ey < vr + vfp + vsw) ? vpol : ~vpol;
      efr = (ex == 0) && (ey == 0);
      eln = (ex == 0);
    end
    cmp({tag, ".x"}, 32'(x_o), 32'(ex));
    cmp({tag, ".y"}, 32'(y_o), 32'(ey));
    cmp({tag, ".de"}, 32'(de_o), 32'(ede));
    cmp({tag, ".hs"}, 32'(hs_o), 32'(ehs));
    cmp({tag, ".vs"}, 32'(vs_o), 32'(evs));
    cmp({tag, ".frame"}, 32'(fr_o), 32'(efr));
    cmp({tag, ".line"}, 32'(ln_o), 32'(eln));
    if (FC_EN) begin
      cmp({tag, ".fcount"}, 32'(fc_o), 32'(efc));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) n = -1;
    else     n = n + 1;
    #1;
    mcheck("A", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0,
           a_hs, a_vs, a_de, a_fr, a_ln, a_x, a_y, a_fc);
    mcheck("B", 1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1,
           b_hs, b_vs, b_de, b_fr, b_ln, b_x, b_y, b_fc);
    mcheck("C", 8, 2, 3, 2, 6, 2, 2, 3, 1'b0, 1'b1,
           c_hs, c_vs, c_de, c_fr, c_ln, c_x, c_y, c_fc);
  endtask

  initial begin
    // hold reset for five edges, checking the reset state each time
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b0;

    // first released stretch: one default line, one wide line, several tiny frames
    for (int i = 0; i < 1700; i++) begin
      step();
      if (n < 800 && a_hs === 1'b0) a_hs_cnt++;
      if (n < 800 && a_ln === 1'b1) a_ln_cnt++;
      if (n < 1650 && b_hs === 1'b1) b_hs_cnt++;
      if (n < 195 && c_de === 1'b1) c_de_cnt++;
      if (n < 195 && c_fr === 1'b1) c_fr_cnt++;
    end
    cmp("A.hs_width", 32'(a_hs_cnt), 32'd96);
    cmp("A.line_pulses", 32'(a_ln_cnt), 32'd1);
    cmp("B.hs_width", 32'(b_hs_cnt), 32'd40);
    cmp("C.de_per_frame", 32'(c_de_cnt), 32'd48);
    cmp("C.frames_per_period", 32'(c_fr_cnt), 32'd1);

    // reset in the middle of C's hsync and vsync (x=11, y=9), then restart
    for (int i = 0; i < 200 && (n % 195) != (9 * 15 + 11); i++) step();
    cmp("C.reached_sync_point", 32'(n % 195), 32'(9 * 15 + 11));
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 600; i++) step();

    // randomized run lengths and reset pulse widths
    for (int k = 0; k < 8; k++) begin
      int run_len, rst_len;
      run_len = int'($urandom_range(1, 400));
      rst_len = int'($urandom_range(1, 3));
      for (int i = 0; i < run_len; i++) step();
      rst = 1'b1;
      for (int i = 0; i < rst_len; i++) step();
      rst = 1'b0;
    end
    for (int i = 0; i < 300; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
